// File: rtl/rgb_to_hsv_stream.sv
// rgb_to_hsv_stream: converts an RGB565 pixel stream into HSV for the ball colour
// classifier. One pixel is in flight at a time, and one restoring divider is shared
// between the saturation and hue steps.
//
// Ports
//   clk, rst_n    clock and asynchronous active-low reset
//   in_valid      a pixel is present on in_r/in_g/in_b
//   in_ready      the block accepts a pixel this cycle (IDLE only)
//   in_r/g/b      RGB565 pixel (green is 6-bit)
//   line_start    the accepted pixel is pixel 0 of a new line
//   write         one-cycle strobe: hue/saturation/value/horiz_count are valid
//   hue           0..359 degrees
//   saturation    0..31
//   value         0..31
//   horiz_count   index of the emitted pixel within its line (saturating)
//
// Configuration macro: HSV_GREY_BYPASS_EN. When it is defined, pixels with
// max-min < GREY_TH skip the divider. When it is undefined, only max==min skips it.
module rgb_to_hsv_stream #(
   parameter int unsigned GREY_TH  = 2,
   parameter int unsigned HCOUNT_W = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4:0]          in_r,
   input  logic [5:0]          in_g,
   input  logic [4:0]          in_b,
   input  logic                line_start,
   output logic                write,
   output logic [8:0]          hue,
   output logic [4:0]          saturation,
   output logic [4:0]          value,
   output logic [HCOUNT_W-1:0] horiz_count
);

   localparam int unsigned DIV_W     = 11;
   localparam int unsigned DIV_STEPS = 11;
   localparam int unsigned CNT_W     = 4;
   localparam logic [HCOUNT_W-1:0] HC_MAX = {HCOUNT_W{1'b1}};

   typedef enum logic [2:0] {IDLE, MINMAX, SAT_DIV, HUE_DIV, EMIT} state_t;

   state_t state, next_state;

   logic                accept;
   logic [4:0]          r_q, g5_q, b_q;
   logic [HCOUNT_W-1:0] line_cnt, line_next, hc_q;
   logic [4:0]          mx_q, d_q, ax_q;
   logic [1:0]          sel_q;
   logic                neg_q;
   logic [4:0]          sat_q;
   logic [5:0]          q_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [4:0]          div_rem, div_den;
   logic [DIV_W-1:0]    div_quo;

   assign accept = in_valid & in_ready;

   // Max/min/delta and the hue numerator from the latched pixel. Ties go to r, then g.
   logic       max_is_r, max_is_g;
   logic [4:0] mx_c, mn_c, d_c, ax_c;
   logic [1:0] sel_c;
   logic       neg_c, grey_c;

   always_comb begin
      max_is_r = (r_q >= g5_q) && (r_q >= b_q);
      max_is_g = !max_is_r && (g5_q >= b_q);
      mx_c  = b_q;
      mn_c  = (r_q <= g5_q) ? r_q : g5_q;
      sel_c = 2'd2;
      ax_c  = (r_q >= g5_q) ? (r_q - g5_q) : (g5_q - r_q);
      neg_c = (r_q < g5_q);
      if (max_is_r) begin
         mx_c  = r_q;
         mn_c  = (g5_q <= b_q) ? g5_q : b_q;
         sel_c = 2'd0;
         ax_c  = (g5_q >= b_q) ? (g5_q - b_q) : (b_q - g5_q);
         neg_c = (g5_q < b_q);
      end else if (max_is_g) begin
         mx_c  = g5_q;
         mn_c  = (r_q <= b_q) ? r_q : b_q;
         sel_c = 2'd1;
         ax_c  = (b_q >= r_q) ? (b_q - r_q) : (r_q - b_q);
         neg_c = (b_q < r_q);
      end
      d_c = mx_c - mn_c;
   end

`ifdef HSV_GREY_BYPASS_EN
   assign grey_c = ({27'd0, d_c} < GREY_TH);
   logic unused_bits;
   assign unused_bits = in_g[0];
`else
   assign grey_c = (d_c == 5'd0);
   logic [5:0] unused_bits;
   assign unused_bits = {in_g[0], 5'(GREY_TH)};
`endif

   // One restoring-divider step: shift the next dividend bit into the remainder.
   logic [5:0]       div_shift;
   logic             div_ge;
   logic [4:0]       rem_next;
   logic [DIV_W-1:0] quo_next;

   always_comb begin
      div_shift = {div_rem, div_quo[DIV_W-1]};
      div_ge    = (div_shift >= {1'b0, div_den});
      rem_next  = div_ge ? 5'(div_shift - {1'b0, div_den}) : div_shift[4:0];
      quo_next  = {div_quo[DIV_W-2:0], div_ge};
   end

   // Line position of the pixel being accepted.
   always_comb begin
      line_next = line_cnt;
      if (line_start)
         line_next = '0;
      else if (line_cnt != HC_MAX)
         line_next = line_cnt + HCOUNT_W'(1);
   end

   // Hue = base + signed offset, wrapped into 0..359.
   logic [8:0] base_c, q9_c, hue_c;

   always_comb begin
      base_c = 9'd0;
      if (sel_q == 2'd1)      base_c = 9'd120;
      else if (sel_q == 2'd2) base_c = 9'd240;
      q9_c = 9'(q_q);
      if (!neg_q)
         hue_c = base_c + q9_c;
      else if (base_c >= q9_c)
         hue_c = base_c - q9_c;
      else
         hue_c = 9'd360 - q9_c;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = MINMAX;
         MINMAX:  next_state = grey_c ? EMIT : SAT_DIV;
         SAT_DIV: if (cnt_q == CNT_W'(DIV_STEPS - 1)) next_state = HUE_DIV;
         HUE_DIV: if (cnt_q == CNT_W'(DIV_STEPS - 1)) next_state = EMIT;
         EMIT:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: pixel capture, line counter, divider sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0; g5_q <= '0; b_q <= '0;
         line_cnt <= '0; hc_q <= '0;
         mx_q <= '0; d_q <= '0; ax_q <= '0; sel_q <= '0; neg_q <= 1'b0;
         sat_q <= '0; q_q <= '0; cnt_q <= '0;
         div_rem <= '0; div_den <= '0; div_quo <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               r_q      <= in_r;
               g5_q     <= in_g[5:1];
               b_q      <= in_b;
               line_cnt <= line_next;
               hc_q     <= line_next;
            end
            MINMAX: begin
               mx_q    <= mx_c;
               d_q     <= d_c;
               ax_q    <= ax_c;
               cnt_q   <= '0;
               div_rem <= '0;
               div_den <= mx_c;
               div_quo <= DIV_W'(DIV_W'(d_c) * DIV_W'(31));
               if (grey_c) begin
                  sel_q <= 2'd0;
                  neg_q <= 1'b0;
                  sat_q <= '0;
                  q_q   <= '0;
               end else begin
                  sel_q <= sel_c;
                  neg_q <= neg_c;
               end
            end
            SAT_DIV: begin
               if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                  sat_q   <= quo_next[4:0];
                  cnt_q   <= '0;
                  div_rem <= '0;
                  div_den <= d_q;
                  div_quo <= DIV_W'(DIV_W'(ax_q) * DIV_W'(60));
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
                  div_rem <= rem_next;
                  div_quo <= quo_next;
               end
            end
            HUE_DIV: begin
               if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
                  q_q   <= quo_next[5:0];
                  cnt_q <= '0;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
                  div_rem <= rem_next;
                  div_quo <= quo_next;
               end
            end
            default: ;
         endcase
      end
   end

   // Registered outputs; results update only on the EMIT edge and then hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready    <= 1'b0;
         write       <= 1'b0;
         hue         <= '0;
         saturation  <= '0;
         value       <= '0;
         horiz_count <= '0;
      end else begin
         in_ready <= (next_state == IDLE);
         write    <= (state == EMIT);
         if (state == EMIT) begin
            hue         <= hue_c;
            saturation  <= sat_q;
            value       <= mx_q;
            horiz_count <= hc_q;
         end
      end
   end

endmodule

// File: tb/tb_rgb_to_hsv_stream.sv
// Scoreboard bench for rgb_to_hsv_stream: expected HSV results are pushed when a pixel
// is accepted and compared (including latency) when write pulses.
module tb_rgb_to_hsv_stream;

   localparam int unsigned GREY_TH  = 2;
   localparam int unsigned HCOUNT_W = 10;
   localparam int          HC_MAX   = (1 << HCOUNT_W) - 1;

   logic                clk, rst_n, in_valid, in_ready, line_start, write;
   logic [4:0]          in_r, in_b, saturation, value;
   logic [5:0]          in_g;
   logic [8:0]          hue;
   logic [HCOUNT_W-1:0] horiz_count;

   rgb_to_hsv_stream #(.GREY_TH(GREY_TH), .HCOUNT_W(HCOUNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .line_start(line_start),
      .write(write), .hue(hue), .saturation(saturation), .value(value),
      .horiz_count(horiz_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int hue; int sat; int val; int hc; int lat; int acc_edge;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   hc_model = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input int r, input int g, input int b, input int hc);
      exp_t e;
      int g5, mx, mn, d, x, ax, q, base, h;
      bit grey;
      g5 = g >> 1;
      if (r >= g5 && r >= b)  begin mx = r;  x = g5 - b; base = 0;   end
      else if (g5 >= b)       begin mx = g5; x = b - r;  base = 120; end
      else                    begin mx = b;  x = r - g5; base = 240; end
      mn = r; if (g5 < mn) mn = g5; if (b < mn) mn = b;
      d = mx - mn;
`ifdef HSV_GREY_BYPASS_EN
      grey = (d < GREY_TH);
`else
      grey = (d == 0);
`endif
      e.hc = hc; e.val = mx; e.acc_edge = 0;
      if (grey) begin
         e.hue = 0; e.sat = 0; e.lat = 2;
      end else begin
         e.sat = (31 * d) / mx;
         ax = (x < 0) ? -x : x;
         q  = (60 * ax) / d;
         h  = base + ((x < 0) ? -q : q);
         if (h < 0) h += 360;
         e.hue = h; e.lat = 24;
      end
      return e;
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   // Monitor: compare on write, push on the edge that will accept, flush on reset.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         hc_model = 0;
         if (write) check("write_in_reset", int'(write), 0);
      end else begin
         if (write) begin
            if (sb.size() == 0) begin
               check("spurious_write", int'(write), 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("hue", int'(hue), e.hue);
               check("saturation", int'(saturation), e.sat);
               check("value", int'(value), e.val);
               check("horiz_count", int'(horiz_count), e.hc);
               check("latency", cyc - e.acc_edge, e.lat);
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            if (line_start)            hc_model = 0;
            else if (hc_model < HC_MAX) hc_model = hc_model + 1;
            e = model(int'(in_r), int'(in_g), int'(in_b), hc_model);
            e.acc_edge = cyc + 1;
            sb.push_back(e);
         end
      end
   end

   task automatic send(input int r, input int g, input int b, input bit ls);
      bit done;
      done = 1'b0;
      in_r = 5'(r); in_g = 6'(g); in_b = 5'(b); line_start = ls;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            done = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      line_start = 1'b0;
      if (!done) check("accept_timeout", int'(in_ready), 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_write"}, int'(write), 0);
      check({tag, "_hue"}, int'(hue), 0);
      check({tag, "_sat"}, int'(saturation), 0);
      check({tag, "_val"}, int'(value), 0);
      check({tag, "_hc"}, int'(horiz_count), 0);
      check({tag, "_ready"}, int'(in_ready), 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; line_start = 1'b0;
      in_r = '0; in_g = '0; in_b = '0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_reset", int'(in_ready), 1);

      // Primary colours, ties, negative offset, mid saturation
      send(31, 0, 0, 1'b1);  drain();
      send(0, 63, 0, 1'b0);  drain();
      send(31, 62, 0, 1'b0); drain();
      send(31, 0, 15, 1'b0); drain();
      send(20, 40, 10, 1'b0); drain();
      send(0, 0, 31, 1'b0);  drain();
      send(5, 6, 30, 1'b0);  drain();
      send(3, 60, 17, 1'b0); drain();

      // Grey and near-grey
      send(10, 20, 10, 1'b0); drain();
      send(10, 22, 10, 1'b0); drain();
      send(0, 0, 0, 1'b0);    drain();

      // Random pixels
      for (int i = 0; i < 12; i++) begin
         send(int'($urandom_range(31)), int'($urandom_range(63)), int'($urandom_range(31)), 1'b0);
         drain();
      end

      // Line positions, in_valid held high while busy
      send(31, 0, 0, 1'b1);
      send(0, 63, 0, 1'b0);
      send(10, 20, 10, 1'b0);
      send(0, 0, 31, 1'b1);
      drain();

      // Saturating line counter on fast grey pixels
      send(7, 14, 7, 1'b1);
      for (int i = 0; i < HC_MAX + 3; i++) send(7, 14, 7, 1'b0);
      drain();

      // Reset in the middle of a conversion
      send(31, 0, 15, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      check_reset_outputs("midreset");
      repeat (3) @(negedge clk);
      check_reset_outputs("midreset_hold");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_midreset", int'(in_ready), 1);
      repeat (30) @(negedge clk);
      send(20, 40, 10, 1'b0); drain();
      send(31, 0, 0, 1'b1);   drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
